// File: rtl/alu_operand_stage.sv
// Execute-stage operand register and 32 x XLEN integer register file.
// Define ALU_OPERAND_BYPASS_EN to forward same-edge write-back into captured operands.
module alu_operand_stage #(
  parameter int XLEN      = 64,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src,
  input  logic [3:0]      alu_ctrl_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] X,
  output logic [XLEN-1:0] Y,
  output logic [3:0]      alu_control,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wb_en,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data
);

  logic [XLEN-1:0] rf [REG_COUNT];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            accept;
  logic            wb_hit;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_addr != 5'd0) &&
                    (int'(wb_addr) < REG_COUNT);

  assign rd1 = (rs1_addr != 5'd0 && int'(rs1_addr) < REG_COUNT)
             ? rf[rs1_addr] : '0;
  assign rd2 = (rs2_addr != 5'd0 && int'(rs2_addr) < REG_COUNT)
             ? rf[rs2_addr] : '0;

`ifdef ALU_OPERAND_BYPASS_EN
  assign src1 = (wb_hit && wb_addr == rs1_addr) ? wb_data : rd1;
  assign src2 = (wb_hit && wb_addr == rs2_addr) ? wb_data : rd2;
`else
  assign src1 = rd1;
  assign src2 = rd2;
`endif

  // Register file write port; x0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++)
        rf[i] <= '0;
    end else if (wb_hit) begin
      rf[wb_addr] <= wb_data;
    end
  end

  // One-entry operand register: capture on accept, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      X           <= '0;
      Y           <= '0;
      rs2_data    <= '0;
      alu_control <= 4'b0000;
    end else if (accept) begin
      out_valid   <= 1'b1;
      X           <= src1;
      Y           <= alu_src ? imm : src2;
      rs2_data    <= src2;
      alu_control <= alu_ctrl_in;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Execute-stage front end that sits directly upstream of the 64-bit ALU.
- Holds the 32 x XLEN integer register file and accepts decoded operand requests over a valid/ready handshake.
- Registers the ALU operands X and Y plus the 4-bit ALU control code, which drive the ALU inputs directly.
- Also takes the write-back port from the downstream stage.

Parameters:
- XLEN, 64, datapath and register width.
- REG_COUNT, 32, number of architectural registers. Address width is fixed at 5 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  decoded request present.
- in_ready  output  1  stage can accept a request this cycle.
- rs1_addr  input  5  source register for X.
- rs2_addr  input  5  source register for Y / store data.
- imm  input  XLEN  sign-extended immediate.
- alu_src  input  1  1: Y = imm; 0: Y = rs2 value.
- alu_ctrl_in  input  4  ALU control code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
- out_valid  output  1  X / Y / alu_control hold a valid operand set.
- out_ready  input  1  ALU side consumes the operand set.
- X  output  XLEN  operand 1.
- Y  output  XLEN  operand 2.
- alu_control  output  4  registered ALU control code.
- rs2_data  output  XLEN  registered rs2 value, always the register and never imm (store data).
- wb_en  input  1  write-back enable.
- wb_addr  input  5  write-back register.
- wb_data  input  XLEN  write-back value.

Behaviour:
- Reset (rst_n low, asynchronous, takes effect immediately):
  - all REG_COUNT registers = 0;
  - out_valid = 0; X = Y = rs2_data = 0; alu_control = 4'b0000.
  - Reset asserted mid-transfer discards the in-flight operand set. The first accept is possible on the first rising edge after rst_n rises.
- Register file:
  - Reads are combinational on rs1_addr / rs2_addr.
  - Writes occur on the rising edge when wb_en = 1 and wb_addr != 0.
  - x0 always reads 0. Writes to x0 are dropped.
  - wb_en is independent of the handshake and is honoured every cycle, including during stalls.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, one-entry pipeline register, no skid).
  - Accept = in_valid && in_ready.
  - Latency is 1 cycle: on an accept edge, out_valid <= 1 and
    - X <= R[rs1_addr];
    - Y <= alu_src ? imm : R[rs2_addr];
    - rs2_data <= R[rs2_addr];
    - alu_control <= alu_ctrl_in.
  - If out_valid && out_ready and there is no accept, out_valid <= 0. X / Y / rs2_data / alu_control keep their last values.
  - Stall (out_valid && !out_ready): all outputs hold bit-stable. No re-read of the register file occurs; a write to a source register during the stall does not update held operands. Hazard handling is the hazard unit's job, not this block's.
  - Simultaneous consume and accept: back-to-back transfer, out_valid stays 1, new operands appear the next cycle.
- No arithmetic in this block. All widths are exactly XLEN; imm is passed unmodified.

Optional Feature:
- Macro: ALU_OPERAND_BYPASS_EN.
- Defined: on an accept edge where wb_en = 1, wb_addr != 0, and wb_addr matches rs1_addr and/or rs2_addr, the captured X, Y (when alu_src = 0) and rs2_data take wb_data (write-through). The register file is written in the same edge.
- Undefined: the captured operands take the pre-write register value; the new value is visible from the following cycle.
- Independent of the macro, x0 never bypasses.

Test Plan:
- Reset: hold rst_n = 0, then release. Then out_valid = 0, X = Y = 0, alu_control = 0000, in_ready = 1. Reading any register via requests returns 0.
- Write then read:
  - wb x5 = 64'h0000AAAA, wb x6 = 64'h00000110.
  - Next cycle request rs1 = 5, rs2 = 6, alu_src = 0, alu_ctrl_in = 0000.
  - One cycle later: out_valid = 1, X = 0000AAAA, Y = 00000110, alu_control = 0000.
- Immediate select: x7 = 750, request rs1 = 7, rs2 = 7, alu_src = 1, imm = 250, alu_ctrl_in = 0010. Expect X = 750, Y = 250, rs2_data = 750.
- x0:
  - wb x0 = 64'hFFFFFFFF.
  - Request rs1 = 0, rs2 = 0, alu_src = 0. Expect X = Y = 0.
- Stall / back-to-back:
  - out_ready = 0 for 3 cycles with in_valid = 1. Outputs are stable and in_ready = 0; a wb to rs1 during the stall leaves X unchanged.
  - Raise out_ready: the queued request is accepted in the same cycle and its operands appear the next cycle.
- Same-cycle write/read:
  - x9 = 128, then wb x9 = 12345 in the same cycle as an accept with rs1 = 9.
  - Expect X = 12345 with ALU_OPERAND_BYPASS_EN defined, X = 128 without.
  - Assert rst_n = 0 during a stall: out_valid drops immediately.
